// File: rtl/usbls_pkg.sv
// usbls_pkg: shared constants for the low-speed USB control-transfer sequencer.
// PID values, sequencer state encodings, err_code values and small decode helpers.
package usbls_pkg;

    // Packet identifiers (upper nibble is the complement of the lower nibble)
    localparam logic [7:0] PID_SETUP = 8'h2D;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;

    // Sequencer states
    localparam logic [3:0] SQ_IDLE    = 4'd0;
    localparam logic [3:0] SQ_S_TOK   = 4'd1;
    localparam logic [3:0] SQ_S_DAT   = 4'd2;
    localparam logic [3:0] SQ_S_WAIT  = 4'd3;
    localparam logic [3:0] SQ_D_TOK   = 4'd4;
    localparam logic [3:0] SQ_D_WAIT  = 4'd5;
    localparam logic [3:0] SQ_D_IPG   = 4'd6;
    localparam logic [3:0] SQ_D_ACK   = 4'd7;
    localparam logic [3:0] SQ_ST_TOK  = 4'd8;
    localparam logic [3:0] SQ_ST_DAT  = 4'd9;
    localparam logic [3:0] SQ_ST_WAIT = 4'd10;
    localparam logic [3:0] SQ_ST_IPG  = 4'd11;
    localparam logic [3:0] SQ_ST_ACK  = 4'd12;
    localparam logic [3:0] SQ_FIN     = 4'd13;

    // err_code values
    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_RETRY = 2'b01;
    localparam logic [1:0] ERR_STALL = 2'b10;
    localparam logic [1:0] ERR_PROTO = 2'b11;

    // A PID byte is well formed when its check nibble complements its type nibble
    function automatic logic pid_check_ok(input logic [7:0] p);
        return (p[7:4] == ~p[3:0]);
    endfunction

    // States in which a packet is handed to the serializer
    function automatic logic is_tx_state(input logic [3:0] s);
        return (s == SQ_S_TOK) || (s == SQ_S_DAT) || (s == SQ_D_TOK) || (s == SQ_D_ACK) ||
               (s == SQ_ST_TOK) || (s == SQ_ST_DAT) || (s == SQ_ST_ACK);
    endfunction

    // States waiting for a device response under timeout
    function automatic logic is_wait_state(input logic [3:0] s);
        return (s == SQ_S_WAIT) || (s == SQ_D_WAIT) || (s == SQ_ST_WAIT);
    endfunction

    // Inter-packet gap states before the host handshake
    function automatic logic is_ipg_state(input logic [3:0] s);
        return (s == SQ_D_IPG) || (s == SQ_ST_IPG);
    endfunction

endpackage

// File: rtl/usbls_seq_timer.sv
// usbls_seq_timer: loadable down-counter shared by the response timeout and the
// inter-packet gap. 'expired' is high while the count sits at zero, so a load of
// N-1 gives exactly N cycles from the cycle after the load up to and including expiry.
module usbls_seq_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] r_count;

    // Reload on request, otherwise count down and stop at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign expired = (r_count == '0);

endmodule

// File: rtl/usbls_ctrl_xfer_seq.sv
// usbls_ctrl_xfer_seq: sequences one low-speed USB control transfer
// (SETUP, optional single IN data packet, status) towards the TX message generator
// and serializer, and checks device responses with timeout, NAK and retry handling.
// Optional feature: define USBLS_SEQ_TOGGLE_CHK_EN to make the data stage accept only
// DATA1; a good DATA0 is then ACKed, discarded and the IN is retried.
module usbls_ctrl_xfer_seq
    import usbls_pkg::*;
#(
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 1024,
    parameter int IPG_CYC     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       has_in_data,
    input  logic       tx_done,
    input  logic       rx_valid,
    input  logic [7:0] rx_pid,
    input  logic       rx_crc_ok,
    output logic       token,
    output logic       data,
    output logic       handshake,
    output logic       setup,
    output logic       in,
    output logic       out,
    output logic [7:0] pid,
    output logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    // Timer just wide enough to hold the larger of the two loaded values
    localparam int TMAX = (TIMEOUT_CYC > IPG_CYC) ? TIMEOUT_CYC : IPG_CYC;
    localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);

    logic [3:0]    r_state;
    logic [3:0]    r_retry;
    logic          r_has_in;
    logic          r_discard;
    logic          r_token, r_data, r_handshake, r_setup, r_in, r_out;
    logic [7:0]    r_pid;
    logic          r_tx_start, r_busy, r_done, r_err;
    logic [1:0]    r_err_code;

    logic [3:0]    w_next;
    logic          w_accept;
    logic          w_fail;
    logic [1:0]    w_fail_code;
    logic          w_retry_req;
    logic [3:0]    w_retry_tgt;
    logic          w_retry_clr;
    logic          w_disc_set;
    logic          w_disc_clr;
    logic          w_exhausted;
    logic [4:0]    w_retry_nxt;
    logic          w_expired;
    logic          w_tmr_load;
    logic [TW-1:0] w_tmr_val;
    logic          w_pid_ok, w_is_ack, w_is_nak, w_is_stall, w_is_data;
    logic          w_token, w_data, w_handshake, w_setup, w_in, w_out;
    logic [7:0]    w_pid;

    // Response decode; a malformed PID never matches any of these
    assign w_pid_ok    = pid_check_ok(rx_pid);
    assign w_is_ack    = w_pid_ok && (rx_pid == PID_ACK);
    assign w_is_nak    = w_pid_ok && (rx_pid == PID_NAK);
    assign w_is_stall  = w_pid_ok && (rx_pid == PID_STALL);
    assign w_is_data   = w_pid_ok && ((rx_pid == PID_DATA0) || (rx_pid == PID_DATA1));

    assign w_retry_nxt = {1'b0, r_retry} + 5'd1;
    assign w_exhausted = (w_retry_nxt >= 5'(MAX_RETRY));
    assign w_accept    = (r_state == SQ_IDLE) && start && !r_err;

    // Next-state logic: transfer sequencing and response classification
    always_comb begin
        w_next      = r_state;
        w_fail      = 1'b0;
        w_fail_code = ERR_NONE;
        w_retry_req = 1'b0;
        w_retry_tgt = SQ_IDLE;
        w_retry_clr = 1'b0;
        w_disc_set  = 1'b0;
        w_disc_clr  = 1'b0;
        case (r_state)
            SQ_IDLE: begin
                if (w_accept) begin
                    w_next      = SQ_S_TOK;
                    w_retry_clr = 1'b1;
                    w_disc_clr  = 1'b1;
                end
            end
            SQ_S_TOK:  if (tx_done) w_next = SQ_S_DAT;
            SQ_S_DAT:  if (tx_done) w_next = SQ_S_WAIT;
            SQ_S_WAIT: begin
                if (rx_valid) begin
                    if (w_is_ack) begin
                        w_next      = r_has_in ? SQ_D_TOK : SQ_ST_TOK;
                        w_retry_clr = 1'b1;
                    end else if (w_is_nak) begin
                        w_retry_req = 1'b1;
                        w_retry_tgt = SQ_S_TOK;
                    end else if (w_is_stall) begin
                        w_fail      = 1'b1;
                        w_fail_code = ERR_STALL;
                    end else begin
                        w_fail      = 1'b1;
                        w_fail_code = ERR_PROTO;
                    end
                end else if (w_expired) begin
                    w_retry_req = 1'b1;
                    w_retry_tgt = SQ_S_TOK;
                end
            end
            SQ_D_TOK: if (tx_done) w_next = SQ_D_WAIT;
            SQ_D_WAIT: begin
                if (rx_valid) begin
                    if (w_is_data && rx_crc_ok) begin
                        w_next = SQ_D_IPG;
`ifdef USBLS_SEQ_TOGGLE_CHK_EN
                        if (rx_pid == PID_DATA0) begin
                            w_disc_set = 1'b1;
                        end else begin
                            w_retry_clr = 1'b1;
                        end
`else
                        w_retry_clr = 1'b1;
`endif
                    end else if (w_is_data || w_is_nak) begin
                        w_retry_req = 1'b1;
                        w_retry_tgt = SQ_D_TOK;
                    end else if (w_is_stall) begin
                        w_fail      = 1'b1;
                        w_fail_code = ERR_STALL;
                    end else begin
                        w_fail      = 1'b1;
                        w_fail_code = ERR_PROTO;
                    end
                end else if (w_expired) begin
                    w_retry_req = 1'b1;
                    w_retry_tgt = SQ_D_TOK;
                end
            end
            SQ_D_IPG: if (w_expired) w_next = SQ_D_ACK;
            SQ_D_ACK: begin
                if (tx_done) begin
                    if (r_discard) begin
                        // A stale DATA0 was acknowledged; ask for the data again
                        w_disc_clr  = 1'b1;
                        w_retry_req = 1'b1;
                        w_retry_tgt = SQ_D_TOK;
                    end else begin
                        w_next      = SQ_ST_TOK;
                        w_retry_clr = 1'b1;
                    end
                end
            end
            SQ_ST_TOK: if (tx_done) w_next = r_has_in ? SQ_ST_DAT : SQ_ST_WAIT;
            SQ_ST_DAT: if (tx_done) w_next = SQ_ST_WAIT;
            SQ_ST_WAIT: begin
                if (rx_valid) begin
                    if (r_has_in && w_is_ack) begin
                        w_next      = SQ_FIN;
                        w_retry_clr = 1'b1;
                    end else if (!r_has_in && w_is_data && rx_crc_ok) begin
                        w_next      = SQ_ST_IPG;
                        w_retry_clr = 1'b1;
                    end else if (w_is_nak || (!r_has_in && w_is_data)) begin
                        w_retry_req = 1'b1;
                        w_retry_tgt = SQ_ST_TOK;
                    end else if (w_is_stall) begin
                        w_fail      = 1'b1;
                        w_fail_code = ERR_STALL;
                    end else begin
                        w_fail      = 1'b1;
                        w_fail_code = ERR_PROTO;
                    end
                end else if (w_expired) begin
                    w_retry_req = 1'b1;
                    w_retry_tgt = SQ_ST_TOK;
                end
            end
            SQ_ST_IPG: if (w_expired) w_next = SQ_ST_ACK;
            SQ_ST_ACK: if (tx_done) w_next = SQ_FIN;
            SQ_FIN:    w_next = SQ_IDLE;
            default:   w_next = SQ_IDLE;
        endcase

        // A retry that would reach the attempt limit becomes a failure instead
        if (w_retry_req) begin
            if (w_exhausted) begin
                w_fail      = 1'b1;
                w_fail_code = ERR_RETRY;
            end else begin
                w_next = w_retry_tgt;
            end
        end
        if (w_fail) begin
            w_next = SQ_IDLE;
        end
    end

    // Packet-type / phase selects and PID for the state being entered
    always_comb begin
        w_token     = 1'b0;
        w_data      = 1'b0;
        w_handshake = 1'b0;
        w_setup     = 1'b0;
        w_in        = 1'b0;
        w_out       = 1'b0;
        w_pid       = 8'h00;
        case (w_next)
            SQ_S_TOK:  begin w_token = 1'b1;     w_setup = 1'b1; w_pid = PID_SETUP; end
            SQ_S_DAT:  begin w_data = 1'b1;      w_setup = 1'b1; w_pid = PID_DATA0; end
            SQ_D_TOK:  begin w_token = 1'b1;     w_in = 1'b1;    w_pid = PID_IN;    end
            SQ_D_ACK:  begin w_handshake = 1'b1; w_in = 1'b1;    w_pid = PID_ACK;   end
            SQ_ST_TOK: begin
                w_token = 1'b1;
                w_out   = r_has_in;
                w_in    = !r_has_in;
                w_pid   = r_has_in ? PID_OUT : PID_IN;
            end
            SQ_ST_DAT: begin w_data = 1'b1;      w_out = 1'b1;   w_pid = PID_DATA1; end
            SQ_ST_ACK: begin w_handshake = 1'b1; w_in = 1'b1;    w_pid = PID_ACK;   end
            default:   w_pid = 8'h00;
        endcase
    end

    // Arm the timer when entering a response wait or an inter-packet gap
    assign w_tmr_load = (w_next != r_state) && (is_wait_state(w_next) || is_ipg_state(w_next));
    assign w_tmr_val  = is_ipg_state(w_next) ? TW'(IPG_CYC - 1) : TW'(TIMEOUT_CYC - 1);

    usbls_seq_timer #(
        .W(TW)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_tmr_load),
        .value   (w_tmr_val),
        .expired (w_expired)
    );

    // State, retry bookkeeping and transfer-type capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= SQ_IDLE;
            r_retry   <= 4'd0;
            r_has_in  <= 1'b0;
            r_discard <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_has_in <= has_in_data;
            end
            if (w_retry_clr) begin
                r_retry <= 4'd0;
            end else if (w_retry_req && !w_exhausted) begin
                r_retry <= w_retry_nxt[3:0];
            end
            if (w_disc_clr) begin
                r_discard <= 1'b0;
            end else if (w_disc_set) begin
                r_discard <= 1'b1;
            end
        end
    end

    // Registered outputs; selects follow the next state so they are clean for the whole TX state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_token     <= 1'b0;
            r_data      <= 1'b0;
            r_handshake <= 1'b0;
            r_setup     <= 1'b0;
            r_in        <= 1'b0;
            r_out       <= 1'b0;
            r_pid       <= 8'h00;
            r_tx_start  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_token     <= w_token;
            r_data      <= w_data;
            r_handshake <= w_handshake;
            r_setup     <= w_setup;
            r_in        <= w_in;
            r_out       <= w_out;
            r_pid       <= w_pid;
            r_tx_start  <= is_tx_state(w_next) && (w_next != r_state);
            r_busy      <= (w_next != SQ_IDLE) && (w_next != SQ_FIN);
            r_done      <= (w_next == SQ_FIN);
            r_err       <= w_fail;
            r_err_code  <= w_fail ? w_fail_code : ERR_NONE;
        end
    end

    assign token     = r_token;
    assign data      = r_data;
    assign handshake = r_handshake;
    assign setup     = r_setup;
    assign in        = r_in;
    assign out       = r_out;
    assign pid       = r_pid;
    assign tx_start  = r_tx_start;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule

// File: tb/tb_usbls_ctrl_xfer_seq.sv
// Directed testbench for usbls_ctrl_xfer_seq (default build; the DATA0 scenario
// adapts its expectation when USBLS_SEQ_TOGGLE_CHK_EN is defined).
module tb_usbls_ctrl_xfer_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       has_in_data = 1'b0;
    logic       tx_done = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_pid = 8'h00;
    logic       rx_crc_ok = 1'b0;
    logic       token, data, handshake, setup, in, out;
    logic [7:0] pid;
    logic       tx_start, busy, done, err;
    logic [1:0] err_code;

    int compared = 0;
    int mismatched = 0;

    logic [7:0] log_q[$];
    int         done_cnt = 0;
    int         err_cnt = 0;
    logic [1:0] last_code = 2'b00;

    always #5 clk = ~clk;

    usbls_ctrl_xfer_seq #(
        .MAX_RETRY   (3),
        .TIMEOUT_CYC (1024),
        .IPG_CYC     (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .has_in_data (has_in_data),
        .tx_done     (tx_done),
        .rx_valid    (rx_valid),
        .rx_pid      (rx_pid),
        .rx_crc_ok   (rx_crc_ok),
        .token       (token),
        .data        (data),
        .handshake   (handshake),
        .setup       (setup),
        .in          (in),
        .out         (out),
        .pid         (pid),
        .tx_start    (tx_start),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_code    (err_code)
    );

    // Record every transmitted PID and every done/err pulse
    always @(negedge clk) begin
        if (tx_start) log_q.push_back(pid);
        if (done) done_cnt++;
        if (err) begin
            err_cnt++;
            last_code = err_code;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_tx(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (tx_start) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic finish_tx();
        ticks(2);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic serve_n(input int n, output bit ok);
        bit o;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            wait_tx(o);
            ok &= o;
            if (o) finish_tx();
        end
    endtask

    task automatic rsp(input logic [7:0] p, input logic c);
        rx_valid  = 1'b1;
        rx_pid    = p;
        rx_crc_ok = c;
        tick();
        rx_valid  = 1'b0;
        rx_pid    = 8'h00;
        rx_crc_ok = 1'b0;
    endtask

    task automatic kick(input logic hid);
        has_in_data = hid;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_log();
        log_q.delete();
        done_cnt  = 0;
        err_cnt   = 0;
        last_code = 2'b00;
    endtask

    function automatic logic [63:0] log_pack();
        logic [63:0] r;
        r = '0;
        foreach (log_q[i]) r = {r[55:0], log_q[i]};
        return r;
    endfunction

    function automatic logic [20:0] all_outs();
        return {token, data, handshake, setup, in, out, pid, tx_start, busy, done, err, err_code};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        ticks(2);
        compared++;
        if (all_outs() !== 21'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %h expected 0", all_outs());
        end
        rst_n = 1'b1;
        ticks(2);
    endtask

    task automatic test_no_data();
        bit ok, ok2;
        clear_log();
        kick(1'b0);
        compared++;
        if ({busy, tx_start, token, setup, pid} !== {4'b1111, 8'h2D}) begin
            mismatched++;
            $display("FAIL nodata_first_tok: got %h expected %h", {busy, tx_start, token, setup, pid}, {4'b1111, 8'h2D});
        end
        serve_n(2, ok);
        ticks(3);
        rsp(8'hD2, 1'b0);
        compared++;
        if ({tx_start, token, in, out, pid} !== {4'b1110, 8'h69}) begin
            mismatched++;
            $display("FAIL nodata_status_in: got %h expected %h", {tx_start, token, in, out, pid}, {4'b1110, 8'h69});
        end
        tick();
        compared++;
        if ({tx_start, token, in, pid} !== {3'b011, 8'h69}) begin
            mismatched++;
            $display("FAIL nodata_held_sel: got %h expected %h", {tx_start, token, in, pid}, {3'b011, 8'h69});
        end
        finish_tx();
        ticks(5);
        rsp(8'h4B, 1'b1);
        serve_n(1, ok2);
        ok &= ok2;
        compared++;
        if ({done, busy} !== 2'b10) begin
            mismatched++;
            $display("FAIL nodata_done_busy: got %b expected 10", {done, busy});
        end
        ticks(3);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL nodata_tx_wait: got timeout expected tx_start");
        end
        compared++;
        if (log_pack() !== 64'h2DC369D2 || done_cnt != 1 || err_cnt != 0) begin
            mismatched++;
            $display("FAIL nodata_seq: got %h done=%0d err=%0d expected 2dc369d2 done=1 err=0", log_pack(), done_cnt, err_cnt);
        end
    endtask

    task automatic test_with_data();
        bit ok, o;
        int n;
        clear_log();
        kick(1'b1);
        serve_n(2, ok);
        ticks(2);
        rsp(8'hD2, 1'b0);
        serve_n(1, o); ok &= o;
        ticks(4);
        rsp(8'h4B, 1'b1);
        n = 0;
        while (!tx_start && n < 50) begin
            tick();
            n++;
        end
        compared++;
        if (n != 4 || pid !== 8'hD2 || handshake !== 1'b1) begin
            mismatched++;
            $display("FAIL data_ipg: got %0d cycles pid %h expected 4 cycles pid d2", n, pid);
        end
        finish_tx();
        serve_n(2, o); ok &= o;
        ticks(3);
        rsp(8'hD2, 1'b0);
        compared++;
        if ({done, busy, err} !== 3'b100) begin
            mismatched++;
            $display("FAIL data_done: got %b expected 100", {done, busy, err});
        end
        ticks(2);
        compared++;
        if (!ok || log_pack() !== 64'h2DC369D2E14B || done_cnt != 1) begin
            mismatched++;
            $display("FAIL data_seq: got %h done=%0d ok=%0d expected 2dc369d2e14b done=1", log_pack(), done_cnt, ok);
        end
    endtask

    task automatic test_nak_retry();
        bit ok, o;
        int n_in;
        clear_log();
        kick(1'b1);
        serve_n(2, ok);
        ticks(2);
        rsp(8'hD2, 1'b0);
        serve_n(1, o); ok &= o;
        ticks(2);
        rsp(8'h5A, 1'b0);
        serve_n(1, o); ok &= o;
        ticks(2);
        rsp(8'h5A, 1'b0);
        serve_n(1, o); ok &= o;
        ticks(2);
        compared++;
        if (dut.r_retry !== 4'd2) begin
            mismatched++;
            $display("FAIL nak_retry_cnt: got %0d expected 2", dut.r_retry);
        end
        rsp(8'h4B, 1'b1);
        serve_n(3, o); ok &= o;
        ticks(2);
        rsp(8'hD2, 1'b0);
        ticks(2);
        n_in = 0;
        foreach (log_q[i]) if (log_q[i] == 8'h69) n_in++;
        compared++;
        if (!ok || n_in != 3 || done_cnt != 1 || err_cnt != 0) begin
            mismatched++;
            $display("FAIL nak_seq: got in=%0d done=%0d err=%0d ok=%0d expected in=3 done=1 err=0", n_in, done_cnt, err_cnt, ok);
        end
    endtask

    task automatic test_timeout();
        bit ok, o;
        int n;
        clear_log();
        kick(1'b0);
        serve_n(2, ok);
        for (int a = 0; a < 3; a++) begin
            n = 0;
            while (!(a < 2 ? tx_start : err) && n < 1100) begin
                tick();
                n++;
            end
            compared++;
            if (n != 1024) begin
                mismatched++;
                $display("FAIL timeout_len[%0d]: got %0d expected 1024", a, n);
            end
            if (a < 2) begin
                serve_n(2, o);
                ok &= o;
            end
        end
        compared++;
        if ({err, err_code, busy} !== 4'b1010) begin
            mismatched++;
            $display("FAIL timeout_err: got %b expected 1010", {err, err_code, busy});
        end
        ticks(2);
        compared++;
        if (!ok || log_pack() !== 64'h2DC32DC32DC3 || err_cnt != 1 || done_cnt != 0) begin
            mismatched++;
            $display("FAIL timeout_seq: got %h err=%0d done=%0d expected 2dc32dc32dc3 err=1 done=0", log_pack(), err_cnt, done_cnt);
        end
    endtask

    task automatic test_stall();
        bit ok, o;
        clear_log();
        kick(1'b1);
        serve_n(2, ok);
        ticks(2);
        rsp(8'hD2, 1'b0);
        serve_n(1, o); ok &= o;
        ticks(3);
        rsp(8'h1E, 1'b0);
        compared++;
        if ({err, err_code, busy} !== 4'b1100) begin
            mismatched++;
            $display("FAIL stall_err: got %b expected 1100", {err, err_code, busy});
        end
        compared++;
        if ({token, data, handshake, setup, in, out, pid, tx_start} !== 15'd0) begin
            mismatched++;
            $display("FAIL stall_selects: got %h expected 0", {token, data, handshake, setup, in, out, pid, tx_start});
        end
        has_in_data = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        compared++;
        if ({busy, tx_start} !== 2'b00) begin
            mismatched++;
            $display("FAIL stall_start_ignored: got %b expected 00", {busy, tx_start});
        end
        ticks(2);
        compared++;
        if (!ok || err_cnt != 1 || last_code !== 2'b10) begin
            mismatched++;
            $display("FAIL stall_count: got err=%0d code=%b ok=%0d expected err=1 code=10", err_cnt, last_code, ok);
        end
    endtask

    task automatic test_data0();
        bit ok, o;
        logic [7:0] exp_next;
`ifdef USBLS_SEQ_TOGGLE_CHK_EN
        exp_next = 8'h69;
`else
        exp_next = 8'hE1;
`endif
        clear_log();
        kick(1'b1);
        serve_n(2, ok);
        ticks(2);
        rsp(8'hD2, 1'b0);
        serve_n(1, o); ok &= o;
        ticks(2);
        rsp(8'hC3, 1'b1);
        wait_tx(o); ok &= o;
        compared++;
        if (pid !== 8'hD2) begin
            mismatched++;
            $display("FAIL data0_ack: got %h expected d2", pid);
        end
        finish_tx();
        compared++;
        if (tx_start !== 1'b1 || pid !== exp_next) begin
            mismatched++;
            $display("FAIL data0_next: got %h expected %h", pid, exp_next);
        end
`ifdef USBLS_SEQ_TOGGLE_CHK_EN
        finish_tx();
        ticks(2);
        rsp(8'h4B, 1'b1);
        serve_n(1, o); ok &= o;
`endif
        serve_n(2, o); ok &= o;
        ticks(2);
        rsp(8'hD2, 1'b0);
        ticks(2);
        compared++;
        if (!ok || done_cnt != 1 || err_cnt != 0) begin
            mismatched++;
            $display("FAIL data0_done: got done=%0d err=%0d ok=%0d expected done=1 err=0", done_cnt, err_cnt, ok);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_log();
        kick(1'b0);
        serve_n(1, ok);
        tick();
        compared++;
        if ({ok, data, setup, pid} !== {3'b111, 8'hC3}) begin
            mismatched++;
            $display("FAIL rstmid_in_sdat: got %h expected %h", {ok, data, setup, pid}, {3'b111, 8'hC3});
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if (all_outs() !== 21'd0) begin
            mismatched++;
            $display("FAIL rstmid_outputs: got %h expected 0", all_outs());
        end
        tick();
        rst_n = 1'b1;
        ticks(3);
        compared++;
        if (done_cnt != 0 || err_cnt != 0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL rstmid_quiet: got done=%0d err=%0d busy=%b expected 0 0 0", done_cnt, err_cnt, busy);
        end
    endtask

    task automatic test_rx_at_expiry();
        bit ok;
        clear_log();
        kick(1'b0);
        serve_n(2, ok);
        ticks(1023);
        rsp(8'hD2, 1'b0);
        compared++;
        if (!ok || tx_start !== 1'b1 || pid !== 8'h69 || err_cnt != 0) begin
            mismatched++;
            $display("FAIL expiry_rx_wins: got pid %h tx_start %b err=%0d expected pid 69 tx_start 1 err=0", pid, tx_start, err_cnt);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ticks(2);
    endtask

    task automatic test_protocol();
        bit ok, o;
        clear_log();
        kick(1'b0);
        rsp(8'h1E, 1'b0);
        compared++;
        if ({err, busy} !== 2'b01) begin
            mismatched++;
            $display("FAIL proto_rx_ignored: got %b expected 01", {err, busy});
        end
        finish_tx();
        serve_n(1, ok);
        start = 1'b1;
        tick();
        start = 1'b0;
        compared++;
        if ({tx_start, busy} !== 2'b01) begin
            mismatched++;
            $display("FAIL proto_start_busy: got %b expected 01", {tx_start, busy});
        end
        rsp(8'hD2, 1'b0);
        serve_n(1, o); ok &= o;
        ticks(2);
        rsp(8'h4B, 1'b0);
        compared++;
        if ({tx_start, pid} !== {1'b1, 8'h69}) begin
            mismatched++;
            $display("FAIL proto_badcrc_retry: got %h expected 169", {tx_start, pid});
        end
        serve_n(1, o); ok &= o;
        ticks(2);
        rsp(8'h2E, 1'b1);
        compared++;
        if ({err, err_code, busy} !== 4'b1110) begin
            mismatched++;
            $display("FAIL proto_bad_pid: got %b expected 1110", {err, err_code, busy});
        end
        ticks(2);
        compared++;
        if (!ok || log_pack() !== 64'h2DC36969 || err_cnt != 1) begin
            mismatched++;
            $display("FAIL proto_seq: got %h err=%0d ok=%0d expected 2dc36969 err=1", log_pack(), err_cnt, ok);
        end
    endtask

    initial begin
        test_reset();
        test_no_data();
        test_with_data();
        test_nak_retry();
        test_timeout();
        test_stall();
        test_data0();
        test_reset_mid();
        test_rx_at_expiry();
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
